sumador_serial_ctrl: RTL
========================

Name: sumador_serial_ctrl

Overview:
- Sequencer that performs a WIDTH-bit addition by time-multiplexing one external one-bit full adder (sumador_completo) over WIDTH cycles, LSB first.
- Holds the operands and the carry, drives the full adder's inputs, and collects its outputs.
- Presents valid/ready handshakes on the operand and result sides.
- Used in the power-analysis flow as the bit-serial counterpart to the parallel ripple adder.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).
- CNT_W, 6, width of the internal bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_L  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  controller can accept operands.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- ci_in  input  1  carry-in.
- fa_a  output  1  full-adder input a.
- fa_b  output  1  full-adder input b.
- fa_ci  output  1  full-adder input ci.
- fa_s  input  1  full-adder sum output (combinational from fa_*).
- fa_co  input  1  full-adder carry output.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result sum.
- co  output  1  result carry-out.
- busy  output  1  high in ADD or DONE.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low on reset_L.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, co=0, fa_a/fa_b/fa_ci=0, bit counter=0, operand and carry registers=0.
- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch a_in into shift reg A, b_in into shift reg B, ci_in into carry reg; clear sum reg and counter; go to ADD.
  - in_valid low: stay in IDLE.
- ADD:
  - in_ready=0.
  - Combinationally fa_a=A[0], fa_b=B[0], fa_ci=carry.
  - Each edge: A>>=1, B>>=1, sum_reg={fa_s, sum_reg[WIDTH-1:1]}, carry<=fa_co, counter++.
  - When counter==WIDTH-1 at an edge: perform the final shift, move to DONE.
  - Exactly WIDTH cycles are spent in ADD.
- DONE:
  - out_valid=1, sum=sum_reg, co=carry; both held stable while out_ready=0.
  - On out_valid&&out_ready at an edge: go to IDLE, out_valid drops next cycle.
- Outside ADD, fa_a/fa_b/fa_ci are forced to 0 to avoid needless toggling in power runs.
- Latency: accept edge E0; out_valid high after edge E0+WIDTH; earliest next accept at edge E0+WIDTH+2 when out_ready is held 1.
- No overlap: in_valid while busy is ignored; operands are not queued; in_ready stays 0.
- sum/co outputs retain the last result after out_valid falls, until the next DONE; only out_valid qualifies them.
- Width rules:
  - Addition is modulo 2^WIDTH with carry-out in co.
  - co is the carry out of bit WIDTH-1 including ci_in.
  - WIDTH=1 spends one cycle in ADD.
- Reset mid-operation: asserting reset_L=0 in any state aborts immediately and returns all outputs to their reset values. No partial result is ever presented.
- Simultaneous in_valid and reset deassertion: the first accept is possible at the first rising edge with reset_L=1.
- The full adder is purely combinational; the controller samples fa_s/fa_co at the same edge that shifts the operands. No extra pipeline stage.

Test Plan:
- Sum without carry-out: WIDTH=8, a_in=0x5A, b_in=0x33, ci_in=0, out_ready=1 -> out_valid exactly 8 cycles after accept, sum=0x8D, co=0; in_ready back to 1 two edges later.
- Wrap-around with carry: a_in=0xFF, b_in=0x01, ci_in=0 -> sum=0x00, co=1. Then a_in=0xFF, b_in=0xFF, ci_in=1 -> sum=0xFF, co=1.
- Result backpressure: a_in=0x10, b_in=0x20, out_ready=0 for 5 cycles after out_valid -> out_valid, sum=0x30 and co=0 stable for all 5 cycles; state leaves DONE only on the edge where out_ready=1.
- Ignored request while busy: in_valid=1 held with a_in=0xAA, b_in=0x55 changing to 0x01/0x01 during ADD -> in_ready=0 throughout, result=0xFF co=0 from the first operands; 0x01+0x01 accepted only after return to IDLE -> sum=0x02.
- Reset mid-operation: reset_L=0 for one cycle after 3 ADD cycles -> out_valid never asserts, busy=0, in_ready=1, sum=0. A following 0x0F+0x01 request yields sum=0x10, co=0.
- Serial port activity: WIDTH=1, a_in=1, b_in=1, ci_in=1 -> one ADD cycle, sum=1, co=1; fa_a/fa_b/fa_ci nonzero only during that cycle.

Source files
------------

// File: rtl/sumador_serial_ctrl.sv
// sumador_serial_ctrl: bit-serial WIDTH-bit adder sequencer. One external combinational full
// adder is reused for WIDTH cycles, LSB first. The controller holds the operands and carry,
// drives the adder inputs and shifts its sum bits into a result register.
//
// Ports:
//   clk, reset_L                 clock, asynchronous active-low reset
//   in_valid/in_ready            operand handshake (a_in, b_in, ci_in)
//   fa_a, fa_b, fa_ci            full-adder inputs (held at 0 outside ADD)
//   fa_s, fa_co                  full-adder outputs, sampled on the shifting edge
//   out_valid/out_ready          result handshake (sum, co)
//   busy                         high while an addition is in flight or being presented
module sumador_serial_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ci_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, sum_q, sum_shift, res_q;
  logic               carry_q, res_co_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept, last_bit;

  assign accept   = (state_q == StIdle) && in_valid;
  assign last_bit = (state_q == StAdd) && (cnt_q == CNT_W'(WIDTH - 1));

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
  always_comb begin
    sum_shift            = sum_q >> 1;
    sum_shift[WIDTH-1]   = fa_s;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StAdd;
      StAdd:   if (last_bit) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_ci     = 1'b0;
    unique case (state_q)
      StIdle: in_ready = 1'b1;
      StAdd: begin
        busy  = 1'b1;
        fa_a  = a_q[0];
        fa_b  = b_q[0];
        fa_ci = carry_q;
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath. res_q/res_co_q keep the last result visible after DONE while sum_q is reused.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      res_co_q <= 1'b0;
    end else if (accept) begin
      a_q     <= a_in;
      b_q     <= b_in;
      carry_q <= ci_in;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == StAdd) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sum_q   <= sum_shift;
      carry_q <= fa_co;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_bit) begin
        res_q    <= sum_shift;
        res_co_q <= fa_co;
      end
    end
  end

  assign sum = res_q;
  assign co  = res_co_q;

endmodule
